// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared types and frame-length helper for the UART TX path.
//            The parity field only counts when UART_FRAME_TX_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_e;

`ifdef UART_FRAME_TX_PARITY_EN
    localparam bit c_PARITY_BUILT = 1'b1;
`else
    localparam bit c_PARITY_BUILT = 1'b0;
`endif

    // Frame length in baud ticks: start + data + optional parity + stop.
    function automatic int uart_frame_len(input int data_bits, input int stop_bits,
                                          input parity_e parity);
        int p;
        p = (c_PARITY_BUILT && (parity != PAR_NONE)) ? 1 : 0;
        return 1 + data_bits + p + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_byte
// Brief    : Single-byte UART frame engine; parity state exists only when
//            UART_FRAME_TX_PARITY_EN is defined.
// Revision : 1.0
// ============================================================================
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int      DATA_BITS = 8,
    parameter int      STOP_BITS = 1,
    parameter parity_e PARITY    = PAR_NONE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_tick,
    input  logic                 byte_valid,
    input  logic [DATA_BITS-1:0] byte_data,
    output logic                 byte_take,
    output logic                 byte_done,
    output logic                 tx
);

    localparam int                 c_BIT_W      = $clog2(DATA_BITS + 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST   = c_BIT_W'(DATA_BITS);
    localparam logic [1:0]         c_STOP_LAST  = 2'(STOP_BITS);
    localparam bit                 c_PAR_ACTIVE = c_PARITY_BUILT && (PARITY != PAR_NONE);

    uart_tx_state_e         state_q;
    logic [DATA_BITS-1:0]   sh_q;
    logic [c_BIT_W-1:0]     bit_cnt_q;
    logic [1:0]             stop_cnt_q;
    logic                   tx_q;
`ifdef UART_FRAME_TX_PARITY_EN
    logic                   par_q;
`endif

    logic w_stop_end;
    logic w_take;

    assign w_stop_end = baud_tick && (state_q == ST_STOP) && (stop_cnt_q == c_STOP_LAST);
    // A new byte starts either from idle or on the very tick that ends the
    // previous stop period, which is what gives back-to-back bytes no gap.
    assign w_take     = byte_valid && ((baud_tick && (state_q == ST_IDLE)) || w_stop_end);

    assign byte_take = w_take;
    assign byte_done = w_stop_end;
    assign tx        = tx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sh_q       <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            tx_q       <= 1'b1;
`ifdef UART_FRAME_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else if (w_take) begin
            state_q    <= ST_START;
            sh_q       <= byte_data;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            tx_q       <= 1'b0;
`ifdef UART_FRAME_TX_PARITY_EN
            par_q      <= (PARITY == PAR_ODD) ? ~^byte_data : ^byte_data;
`endif
        end else if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                end
                ST_START: begin
                    state_q   <= ST_DATA;
                    tx_q      <= sh_q[0];
                    sh_q      <= sh_q >> 1;
                    bit_cnt_q <= c_BIT_W'(1);
                end
                ST_DATA: begin
                    if (bit_cnt_q == c_BIT_LAST) begin
                        if (c_PAR_ACTIVE) begin
`ifdef UART_FRAME_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= par_q;
`endif
                        end else begin
                            state_q    <= ST_STOP;
                            tx_q       <= 1'b1;
                            stop_cnt_q <= 2'd1;
                        end
                    end else begin
                        tx_q      <= sh_q[0];
                        sh_q      <= sh_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
`ifdef UART_FRAME_TX_PARITY_EN
                ST_PARITY: begin
                    state_q    <= ST_STOP;
                    tx_q       <= 1'b1;
                    stop_cnt_q <= 2'd1;
                end
`endif
                ST_STOP: begin
                    if (w_stop_end) begin
                        state_q    <= ST_IDLE;
                        tx_q       <= 1'b1;
                        stop_cnt_q <= '0;
                    end else begin
                        stop_cnt_q <= stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_tx
// Brief    : Multi-byte UART packet transmitter with valid/ready intake and a
//            done pulse; parity honoured only with UART_FRAME_TX_PARITY_EN.
// Revision : 1.0
// ============================================================================
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int      DATA_BITS = 8,
    parameter int      STOP_BITS = 1,
    parameter parity_e PARITY    = PAR_NONE,
    parameter int      NUM_BYTES = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           baud_tick,
    input  logic [NUM_BYTES*DATA_BITS-1:0] pkt_data,
    input  logic                           pkt_valid,
    output logic                           pkt_ready,
    output logic                           tx,
    output logic                           busy,
    output logic                           done
);

    localparam int                 c_PKT_W    = NUM_BYTES * DATA_BITS;
    localparam int                 c_CNT_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(NUM_BYTES - 1);

    logic [c_PKT_W-1:0] pkt_q;
    logic [c_CNT_W-1:0] byte_cnt_q;
    logic               busy_q;
    logic               first_q;
    logic               done_q;

    logic w_accept;
    logic w_more;
    logic w_take;
    logic w_byte_done;

    assign pkt_ready = rst_n && !busy_q;
    assign w_accept  = pkt_valid && pkt_ready;
    // first_q holds off byte 0 until a tick strictly after acceptance.
    assign w_more    = busy_q && (first_q || (byte_cnt_q != c_LAST_IDX));

    assign busy = busy_q;
    assign done = done_q;

    uart_tx_byte #(
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .PARITY    (PARITY)
    ) u_byte (
        .clk        (clk),
        .rst_n      (rst_n),
        .baud_tick  (baud_tick),
        .byte_valid (w_more),
        .byte_data  (pkt_q[DATA_BITS-1:0]),
        .byte_take  (w_take),
        .byte_done  (w_byte_done),
        .tx         (tx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_q      <= '0;
            byte_cnt_q <= '0;
            busy_q     <= 1'b0;
            first_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (w_accept) begin
                pkt_q      <= pkt_data;
                byte_cnt_q <= '0;
                busy_q     <= 1'b1;
                first_q    <= 1'b1;
            end else if (w_take) begin
                pkt_q   <= pkt_q >> DATA_BITS;
                first_q <= 1'b0;
                if (!first_q) begin
                    byte_cnt_q <= byte_cnt_q + 1'b1;
                end
            end else if (w_byte_done) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised multi-byte UART transmitter: accepts a packet of NUM_BYTES words over a valid/ready handshake and serialises it on `tx`, byte 0 first, each byte framed with start, data (LSB first), optional parity and 1–2 stop bits. Bit timing comes from an external single-cycle `baud_tick`. It sits between the command/response path and the board TX pin. It generalises the fixed 3-byte 8N1 transmitter with configurable widths, parity, stop bits, a proper handshake and a completion pulse.

## Interface
- DATA_BITS, 8, data bits per byte (5–9)
- STOP_BITS, 1, stop bits per byte (1 or 2)
- PARITY, PAR_NONE, parity mode (`parity_e`); honoured only when UART_FRAME_TX_PARITY_EN is defined
- NUM_BYTES, 3, bytes per packet (≥1)
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- baud_tick  in  1  one-clk pulse per bit period
- pkt_data  in  NUM_BYTES*DATA_BITS  packet; byte i = bits [i*DATA_BITS +: DATA_BITS]
- pkt_valid  in  1  packet offered
- pkt_ready  out  1  high only in IDLE; transfer when pkt_valid && pkt_ready on a clk edge
- tx  out  1  serial line, idle high
- busy  out  1  high from acceptance until done
- done  out  1  one-clk pulse when the last stop bit completes

## Operation
- Reset (rst_n low at a clk edge): state IDLE, tx=1, busy=0, done=0, counters 0. pkt_ready=0 while rst_n is low.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: pkt_ready=1. On handshake, capture pkt_data into the shift register, set busy=1, byte_cnt=0, and go to START. tx stays 1.
- All transitions below occur only on clk edges where baud_tick=1. Each state's tx value is registered at entry, so it holds for exactly one tick period.
- START: drive tx=0. Go to DATA.
- DATA: drive the current LSB, shift right, and increment bit_cnt. After DATA_BITS bits, go to PARITY if parity is active, else STOP.
- PARITY: tx is the parity bit. Odd mode: ~^byte. Even mode: ^byte. The bit is computed over the original byte.
- STOP: drive tx=1 for STOP_BITS ticks. On the tick that ends the final stop period:
  - If byte_cnt<NUM_BYTES-1: increment byte_cnt and drive the next start bit on that same tick. There is no inter-byte gap.
  - Otherwise: go to IDLE, tx=1, busy=0, and pulse done for that one cycle.
- Ticks in IDLE are ignored. pkt_data changes after acceptance have no effect.
- Counter widths: bit_cnt $clog2(DATA_BITS+1); byte_cnt $clog2(NUM_BYTES), minimum 1 bit. Neither counter wraps mid-packet.

## Timing
- FRAME = 1 + DATA_BITS + P + STOP_BITS ticks, where P=1 if parity is active.
- Start bit of byte 0 begins on the first baud_tick strictly after the acceptance cycle. A tick coinciding with acceptance is ignored.
- done is asserted on tick number NUM_BYTES*FRAME + 1, counted from that first tick. The line goes low-to-idle with no dead tick between bytes.
- The earliest next acceptance is the cycle after done, when pkt_ready=1 again. Back-to-back packets therefore have ≥1 tick of idle-high between them.
- Reset mid-packet aborts the packet: tx=1 the next cycle, no done pulse, and the packet is discarded.
- baud_tick must be spaced ≥2 clk cycles apart. Consecutive-cycle ticks are unsupported.

## Configuration
- UART_FRAME_TX_PARITY_EN defined: PARITY selects none, odd or even, and the PARITY state is built.
- Undefined: the PARITY state and parity logic are compiled out, P=0, and the PARITY parameter is ignored. Timing is identical to PAR_NONE.

## Structure
- Shared package `uart_pkg`:
  - `parity_e` {PAR_NONE, PAR_ODD, PAR_EVEN}
  - `uart_tx_state_e`
  - `function uart_frame_len(DATA_BITS, STOP_BITS, parity)`
- The command response is packed into pkt_data by the caller, not in this block.
- One sub-module, `uart_tx_byte`: a single-byte frame engine with start/data/parity/stop and byte_valid/byte_done. The top level sequences bytes and the handshake. Zero inter-byte gap requires byte_done-to-next-start in the same tick.

## Test plan
- Default 8N1, NUM_BYTES=3, pkt_data=24'hA5_3C_81: line samples per tick are 0,1000_0001 (LSB first),1, then 0,0011_1100,1, then 0,1010_0101,1. done on tick 31, busy low afterwards, tx idle 1.
- Parity even, DATA_BITS=7, 2 stop bits, NUM_BYTES=1, byte 7'h55: sequence 0,1010101,0,1,1. done on tick 12. Repeat with odd parity: parity bit=1.
- Macro undefined, PARITY=PAR_EVEN: same as 8N1 (parity ignored), FRAME=10.
- pkt_valid high with baud_tick in the same cycle as acceptance: that tick is ignored. Start bit appears on the next tick. pkt_ready is low throughout the packet, and a second pkt_valid is held off until after done.
- rst_n low during byte 1 data bits: tx=1 next cycle, no done, pkt_ready=1 after release. A fresh packet then transmits correctly.
- Two packets offered back-to-back: the second is accepted the cycle after done. Exactly one idle tick (tx=1) before its start bit.
